// File: rtl/gray_rd_arbiter.sv
// gray_rd_arbiter
// Shares the single gray-image read port between two pixel engines.
// Round-robin arbitration with an optional lock, capped at MAX_BURST
// consecutive locked grants. Every issued read carries a requester tag
// through an RD_LAT-deep pipe so the returned pixel goes back to its owner.
//
// Ports
//   clk, reset            clock (rising edge), synchronous active-high reset
//   req0/lock0/addr0      requester 0: read request, keep-ownership hint, address
//   gnt0                  combinational grant for requester 0
//   rdata0/rvalid0        returned pixel for requester 0, one-cycle valid pulse
//   req1 ... rvalid1      same set for requester 1
//   gray_addr/gray_req    registered memory read address / strobe
//   gray_ready            memory can accept a read this cycle
//   gray_data             memory read data, valid RD_LAT cycles after the grant
//   owner                 registered lock status: 00 none, 01 req0, 10 req1
module gray_rd_arbiter #(
   parameter int AW        = 14,
   parameter int DW        = 8,
   parameter int RD_LAT    = 1,
   parameter int MAX_BURST = 9
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          req0,
   input  logic          lock0,
   input  logic [AW-1:0] addr0,
   output logic          gnt0,
   output logic [DW-1:0] rdata0,
   output logic          rvalid0,
   input  logic          req1,
   input  logic          lock1,
   input  logic [AW-1:0] addr1,
   output logic          gnt1,
   output logic [DW-1:0] rdata1,
   output logic          rvalid1,
   output logic [AW-1:0] gray_addr,
   output logic          gray_req,
   input  logic          gray_ready,
   input  logic [DW-1:0] gray_data,
   output logic [1:0]    owner
);

   localparam int CW = $clog2(MAX_BURST + 1);

   // The state encoding doubles as the owner code.
   typedef enum logic [1:0] {
      ST_FREE  = 2'b00,
      ST_LOCK0 = 2'b01,
      ST_LOCK1 = 2'b10
   } state_t;

   state_t        state_reg, state_next;
   logic          rr_ptr_reg, rr_ptr_next;   // 0: req0 favoured, 1: req1 favoured
   logic [CW-1:0] count_reg, count_next;     // beats granted in the current lock

   logic          arb_free;                  // this cycle is arbitrated normally
   logic          pref;                      // side that wins a tie this cycle

   // Tag pipe: valid bit and requester id for each read in flight.
   logic          tag_vld_reg [RD_LAT];
   logic          tag_id_reg  [RD_LAT];
   logic          ret_vld;
   logic          ret_id;

   // ------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg  <= ST_FREE;
         rr_ptr_reg <= 1'b0;
         count_reg  <= '0;
      end else begin
         state_reg  <= state_next;
         rr_ptr_reg <= rr_ptr_next;
         count_reg  <= count_next;
      end
   end

   assign owner = state_reg;

   // ------------------------------------------------------------------
   // Grant and next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      state_next  = state_reg;
      rr_ptr_next = rr_ptr_reg;
      count_next  = count_reg;
      gnt0        = 1'b0;
      gnt1        = 1'b0;
      arb_free    = 1'b1;
      pref        = rr_ptr_reg;

      // Without gray_ready nothing is granted and all state holds.
      if (gray_ready) begin
         case (state_reg)
            ST_LOCK0: begin
               if (req0 && (count_reg < CW'(MAX_BURST))) begin
                  arb_free = 1'b0;
                  gnt0     = 1'b1;
               end else if (req0) begin
                  // Burst cap reached: the other side gets first claim.
                  pref = 1'b1;
               end
            end
            ST_LOCK1: begin
               if (req1 && (count_reg < CW'(MAX_BURST))) begin
                  arb_free = 1'b0;
                  gnt1     = 1'b1;
               end else if (req1) begin
                  pref = 1'b0;
               end
            end
            default: ;
         endcase

         // A dropped request or an expired burst falls through to normal
         // arbitration within the same cycle.
         if (arb_free) begin
            if (req0 && (!req1 || !pref)) begin
               gnt0 = 1'b1;
            end else if (req1) begin
               gnt1 = 1'b1;
            end
         end

         if (gnt0) begin
            rr_ptr_next = 1'b1;
            if (lock0) begin
               state_next = ST_LOCK0;
               count_next = arb_free ? CW'(1) : count_reg + CW'(1);
            end else begin
               state_next = ST_FREE;
               count_next = '0;
            end
         end else if (gnt1) begin
            rr_ptr_next = 1'b0;
            if (lock1) begin
               state_next = ST_LOCK1;
               count_next = arb_free ? CW'(1) : count_reg + CW'(1);
            end else begin
               state_next = ST_FREE;
               count_next = '0;
            end
         end else begin
            state_next = ST_FREE;
            count_next = '0;
         end
      end
   end

   // ------------------------------------------------------------------
   // Read issue
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         gray_req  <= 1'b0;
         gray_addr <= '0;
      end else begin
         gray_req <= gnt0 | gnt1;
         if (gnt0) begin
            gray_addr <= addr0;
         end else if (gnt1) begin
            gray_addr <= addr1;
         end
      end
   end

   // ------------------------------------------------------------------
   // Tag pipe: stage k holds the tag of the read granted k+1 cycles ago,
   // so the last stage lines up with gray_data of that read.
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < RD_LAT; i++) begin
            tag_vld_reg[i] <= 1'b0;
            tag_id_reg[i]  <= 1'b0;
         end
      end else begin
         tag_vld_reg[0] <= gnt0 | gnt1;
         tag_id_reg[0]  <= gnt1;
         for (int i = 1; i < RD_LAT; i++) begin
            tag_vld_reg[i] <= tag_vld_reg[i-1];
            tag_id_reg[i]  <= tag_id_reg[i-1];
         end
      end
   end

   assign ret_vld = tag_vld_reg[RD_LAT-1];
   assign ret_id  = tag_id_reg[RD_LAT-1];

   // ------------------------------------------------------------------
   // Return routing
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         rdata0  <= '0;
         rdata1  <= '0;
         rvalid0 <= 1'b0;
         rvalid1 <= 1'b0;
      end else begin
         rvalid0 <= ret_vld & ~ret_id;
         rvalid1 <= ret_vld & ret_id;
         if (ret_vld && !ret_id) begin
            rdata0 <= gray_data;
         end
         if (ret_vld && ret_id) begin
            rdata1 <= gray_data;
         end
      end
   end

endmodule

// File: tb/tb_gray_rd_arbiter.sv
// tb_gray_rd_arbiter
// Self-checking bench for gray_rd_arbiter: a table of hand-derived grant and
// owner expectations, directed single-read and reset-in-flight sequences, and
// a randomized run. Every cycle is also checked against a reference model that
// tracks the lock holder, beat count, pointer and a queue of pending returns.
module tb_gray_rd_arbiter;

   localparam int AW        = 14;
   localparam int DW        = 8;
   localparam int RD_LAT    = 1;
   localparam int MAX_BURST = 9;

   logic          clk = 1'b0;
   logic          reset;
   logic          req0, lock0, req1, lock1;
   logic [AW-1:0] addr0, addr1;
   logic          gnt0, gnt1, rvalid0, rvalid1;
   logic [DW-1:0] rdata0, rdata1;
   logic [AW-1:0] gray_addr;
   logic          gray_req, gray_ready;
   logic [DW-1:0] gray_data;
   logic [1:0]    owner;

   int checks = 0;
   int errors = 0;

   gray_rd_arbiter #(
      .AW(AW), .DW(DW), .RD_LAT(RD_LAT), .MAX_BURST(MAX_BURST)
   ) dut (
      .clk(clk), .reset(reset),
      .req0(req0), .lock0(lock0), .addr0(addr0), .gnt0(gnt0), .rdata0(rdata0), .rvalid0(rvalid0),
      .req1(req1), .lock1(lock1), .addr1(addr1), .gnt1(gnt1), .rdata1(rdata1), .rvalid1(rvalid1),
      .gray_addr(gray_addr), .gray_req(gray_req), .gray_ready(gray_ready),
      .gray_data(gray_data), .owner(owner)
   );

   always #5 clk = ~clk;

   // Memory with one cycle of read latency: data for the address presented in
   // the cycle after the grant is available in that same cycle.
   function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
      return (a[7:0] ^ {1'b0, a[13:7]}) + 8'hDA;
   endfunction

   assign gray_data = mem_word(gray_addr);

   // ---------------- reference model ----------------
   typedef struct {
      int            due;
      bit            tag;
      logic [DW-1:0] data;
   } ret_t;

   int            holder;      // -1 none, else requester holding the lock
   int            beats;
   bit            ptr;         // requester that wins a tie
   int            cyc;
   ret_t          pend[$];
   bit            exp_greq;
   logic [AW-1:0] exp_gaddr;
   logic [DW-1:0] exp_rd [2];
   bit            exp_rv [2];

   function automatic void model_reset();
      holder    = -1;
      beats     = 0;
      ptr       = 1'b0;
      pend.delete();
      exp_greq  = 1'b0;
      exp_gaddr = '0;
      exp_rd[0] = '0;
      exp_rd[1] = '0;
      exp_rv[0] = 1'b0;
      exp_rv[1] = 1'b0;
   endfunction

   function automatic int model_pick(input bit r[2], input bit rdy);
      bit pref;
      if (!rdy) return -1;
      if (holder >= 0 && r[holder] && beats < MAX_BURST) return holder;
      pref = ptr;
      if (holder >= 0 && r[holder] && beats == MAX_BURST) pref = (holder == 0);
      if (r[0] && r[1]) return pref ? 1 : 0;
      if (r[0]) return 0;
      if (r[1]) return 1;
      return -1;
   endfunction

   function automatic void model_update(input int g, input bit l[2], input bit rdy,
                                        input logic [AW-1:0] a);
      ret_t e;
      if (!rdy) begin
         exp_greq = 1'b0;
         return;
      end
      if (g < 0) begin
         exp_greq = 1'b0;
         holder   = -1;
         beats    = 0;
         return;
      end
      exp_greq  = 1'b1;
      exp_gaddr = a;
      e.due  = cyc + RD_LAT + 1;
      e.tag  = (g == 1);
      e.data = mem_word(a);
      pend.push_back(e);
      if (!l[g]) begin
         holder = -1;
         beats  = 0;
      end else if (holder == g && beats < MAX_BURST) begin
         beats = beats + 1;
      end else begin
         holder = g;
         beats  = 1;
      end
      ptr = (g == 0);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   // One clock cycle: drive inputs, check grants, clock, check registered outputs.
   task automatic step(input bit r0, input bit l0, input bit r1, input bit l1,
                       input bit rdy, input bit rst,
                       input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                       output bit g0, output bit g1);
      int g;
      bit rq[2];
      bit lk[2];
      ret_t e;
      req0 = r0; lock0 = l0; addr0 = a0;
      req1 = r1; lock1 = l1; addr1 = a1;
      gray_ready = rdy;
      reset = rst;
      rq[0] = r0; rq[1] = r1;
      lk[0] = l0; lk[1] = l1;
      #2;
      g  = model_pick(rq, rdy);
      g0 = gnt0;
      g1 = gnt1;
      chk("gnt0", {31'd0, gnt0}, {31'd0, (g == 0)});
      chk("gnt1", {31'd0, gnt1}, {31'd0, (g == 1)});
      @(posedge clk);
      if (rst) model_reset();
      else     model_update(g, lk, rdy, (g == 1) ? a1 : a0);
      cyc++;
      exp_rv[0] = 1'b0;
      exp_rv[1] = 1'b0;
      while (pend.size() > 0 && pend[0].due == cyc) begin
         e = pend.pop_front();
         exp_rv[e.tag] = 1'b1;
         exp_rd[e.tag] = e.data;
      end
      #1;
      chk("gray_req",  {31'd0, gray_req},  {31'd0, exp_greq});
      chk("gray_addr", {18'd0, gray_addr}, {18'd0, exp_gaddr});
      chk("owner",     {30'd0, owner},     (holder < 0) ? 32'd0 : 32'(holder + 1));
      chk("rvalid0",   {31'd0, rvalid0},   {31'd0, exp_rv[0]});
      chk("rvalid1",   {31'd0, rvalid1},   {31'd0, exp_rv[1]});
      chk("rdata0",    {24'd0, rdata0},    {24'd0, exp_rd[0]});
      chk("rdata1",    {24'd0, rdata1},    {24'd0, exp_rd[1]});
      if (exp_rv[0]) $display("cycle %0d RD tag0 data %02h", cyc, exp_rd[0]);
      if (exp_rv[1]) $display("cycle %0d RD tag1 data %02h", cyc, exp_rd[1]);
   endtask

   task automatic do_reset();
      bit g0, g1;
      step(0, 0, 0, 0, 1, 1, '0, '0, g0, g1);
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      bit         r0, l0, r1, l1, rdy;
      logic [1:0] eg;   // {gnt1, gnt0} expected in the cycle
      logic [1:0] eo;   // owner expected after the edge
   } vec_t;

   vec_t tbl[$];

   function automatic void add(input bit r0, input bit l0, input bit r1, input bit l1,
                               input bit rdy, input logic [1:0] eg, input logic [1:0] eo);
      vec_t v;
      v.r0 = r0; v.l0 = l0; v.r1 = r1; v.l1 = l1; v.rdy = rdy;
      v.eg = eg; v.eo = eo;
      tbl.push_back(v);
   endfunction

   initial begin
      bit g0, g1;
      bit rr0, rr1, rl0, rl1, rrdy, rrst;

      cyc = 0;
      model_reset();
      reset = 1'b1;
      req0 = 0; lock0 = 0; addr0 = '0;
      req1 = 0; lock1 = 0; addr1 = '0;
      gray_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // reset state
      chk("rst_gray_req",  {31'd0, gray_req}, 32'd0);
      chk("rst_gray_addr", {18'd0, gray_addr}, 32'd0);
      chk("rst_owner",     {30'd0, owner}, 32'd0);
      chk("rst_rvalid0",   {31'd0, rvalid0}, 32'd0);
      chk("rst_rvalid1",   {31'd0, rvalid1}, 32'd0);
      chk("rst_rdata0",    {24'd0, rdata0}, 32'd0);
      chk("rst_rdata1",    {24'd0, rdata1}, 32'd0);
      reset = 1'b0;

      // round robin, 6 cycles
      for (int i = 0; i < 6; i++) add(1, 0, 1, 0, 1, (i % 2 == 0) ? 2'b01 : 2'b10, 2'b00);
      // lock window: 9 locked beats, forced release to req1
      repeat (9) add(1, 1, 1, 0, 1, 2'b01, 2'b01);
      add(1, 1, 1, 0, 1, 2'b10, 2'b00);
      // early release at the 4th beat
      repeat (3) add(1, 1, 1, 0, 1, 2'b01, 2'b01);
      add(0, 1, 1, 0, 1, 2'b10, 2'b00);
      // stall in FREE, pointer held
      repeat (3) add(1, 0, 1, 0, 0, 2'b00, 2'b00);
      add(1, 1, 1, 0, 1, 2'b01, 2'b01);
      // stall inside a lock does not advance the beat count
      repeat (3) add(1, 1, 1, 0, 0, 2'b00, 2'b01);
      repeat (8) add(1, 1, 1, 0, 1, 2'b01, 2'b01);
      add(1, 1, 1, 0, 1, 2'b10, 2'b00);
      // forced release with the other side idle: immediate re-lock
      repeat (9) add(1, 1, 0, 0, 1, 2'b01, 2'b01);
      add(1, 1, 0, 0, 1, 2'b01, 2'b01);
      add(1, 1, 1, 0, 1, 2'b01, 2'b01);
      add(0, 0, 0, 0, 1, 2'b00, 2'b00);

      for (int i = 0; i < tbl.size(); i++) begin
         step(tbl[i].r0, tbl[i].l0, tbl[i].r1, tbl[i].l1, tbl[i].rdy, 1'b0,
              AW'($urandom), AW'($urandom), g0, g1);
         chk("tbl_gnt",   {30'd0, g1, g0}, {30'd0, tbl[i].eg});
         chk("tbl_owner", {30'd0, owner},  {30'd0, tbl[i].eo});
         $display("VEC %0d req=%0d%0d lock=%0d%0d rdy=%0d gnt=%0d%0d owner=%02b",
                  i, tbl[i].r1, tbl[i].r0, tbl[i].l1, tbl[i].l0, tbl[i].rdy, g1, g0, owner);
      end
      // drain outstanding returns
      step(0, 0, 0, 0, 1, 0, '0, '0, g0, g1);
      step(0, 0, 0, 0, 1, 0, '0, '0, g0, g1);

      // single requester
      do_reset();
      step(1, 0, 0, 0, 1, 0, 14'h0081, '0, g0, g1);
      chk("sr_gnt0",      {31'd0, g0}, 32'd1);
      chk("sr_gray_req",  {31'd0, gray_req}, 32'd1);
      chk("sr_gray_addr", {18'd0, gray_addr}, 32'h0081);
      step(0, 0, 0, 0, 1, 0, '0, '0, g0, g1);
      chk("sr_rvalid0",   {31'd0, rvalid0}, 32'd1);
      chk("sr_rdata0",    {24'd0, rdata0}, 32'h5A);
      chk("sr_rvalid1",   {31'd0, rvalid1}, 32'd0);
      step(0, 0, 0, 0, 1, 0, '0, '0, g0, g1);
      chk("sr_rvalid0_end", {31'd0, rvalid0}, 32'd0);
      $display("DIRECTED single read addr 0081 data %02h", rdata0);

      // reset while a read for req1 is in flight
      do_reset();
      step(0, 0, 1, 1, 1, 0, '0, 14'h1234, g0, g1);
      chk("rf_gnt1", {31'd0, g1}, 32'd1);
      step(0, 0, 0, 0, 1, 1, '0, '0, g0, g1);
      chk("rf_rvalid1_c2", {31'd0, rvalid1}, 32'd0);
      chk("rf_gray_req",   {31'd0, gray_req}, 32'd0);
      chk("rf_owner",      {30'd0, owner}, 32'd0);
      step(0, 0, 0, 0, 1, 0, '0, '0, g0, g1);
      chk("rf_rvalid1_c3", {31'd0, rvalid1}, 32'd0);
      $display("DIRECTED reset in flight owner %02b rvalid1 %0d", owner, rvalid1);

      // randomized traffic against the model
      do_reset();
      for (int i = 0; i < 500; i++) begin
         rr0  = ($urandom_range(0, 9) < 7);
         rr1  = ($urandom_range(0, 9) < 7);
         rl0  = ($urandom_range(0, 9) < 6);
         rl1  = ($urandom_range(0, 9) < 6);
         rrdy = ($urandom_range(0, 9) < 8);
         rrst = ($urandom_range(0, 99) == 0);
         step(rr0, rl0, rr1, rl1, rrdy, rrst, AW'($urandom), AW'($urandom), g0, g1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/gray_rd_arbiter.md
Name: gray_rd_arbiter

Overview:
- Shares the single gray-image read port (gray_addr/gray_req/gray_ready/gray_data) between two pixel engines, e.g. the LBP core and a second window filter.
- Round-robin arbitration with an optional lock, so a requester can keep the port for a 3x3 window fetch. The lock is capped at MAX_BURST beats.
- Tags every issued read and routes the returned pixel back to its owner with an rvalid strobe.

Parameters:
- AW, 14, pixel address width ({row[6:0], col[6:0]}).
- DW, 8, pixel data width.
- RD_LAT, 1, cycles from gray_req/gray_addr driven until gray_data is valid (1..4).
- MAX_BURST, 9, maximum consecutive locked grants to one requester (2..15).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req0  in  1  requester 0 wants one read this cycle.
- lock0  in  1  requester 0 asks to keep ownership after this grant.
- addr0  in  AW  requester 0 read address, valid with req0.
- gnt0  out  1  combinational; read of addr0 accepted this cycle.
- rdata0  out  DW  returned pixel for requester 0.
- rvalid0  out  1  rdata0 valid, one-cycle pulse per read.
- req1, lock1, addr1, gnt1, rdata1, rvalid1  same as requester 0, for requester 1.
- gray_addr  out  AW  registered memory address.
- gray_req  out  1  registered memory read strobe.
- gray_ready  in  1  memory can accept a read this cycle.
- gray_data  in  DW  memory read data.
- owner  out  2  registered lock status: 00 none, 01 req0 holds lock, 10 req1 holds lock.

Behaviour:
- Reset values: gray_req=0, gray_addr=0, rdata0/1=0, rvalid0/1=0, owner=00, rr pointer=0 (req0 favoured), burst count=0, tag pipe cleared.
- Grants are combinational in cycle G. A grant requires gray_ready=1; with gray_ready=0 both gnt are 0 and all state holds.
- At most one gnt per cycle.
- State machine:
  - FREE: grant the sole requester. If both request, grant the rr pointer side; after the grant, the pointer moves to the other side.
  - FREE -> LOCKED_i when gnt_i and lock_i. Burst count is set to 1 and owner=i.
  - LOCKED_i, req_i=1, lock_i=1, count<MAX_BURST: grant i only, even if the other side requests. count+1.
  - LOCKED_i, req_i=1, lock_i=0: final grant to i, then go to FREE.
  - LOCKED_i, req_i=0: release. Go to FREE in the same cycle and arbitrate normally; the other side can win this cycle.
  - LOCKED_i, count==MAX_BURST: forced release. This cycle is arbitrated as FREE with the pointer forced to the other side.
  - If the other side is idle at forced release, i may be granted and re-lock immediately (count=1).
- Issue: on gnt_i at edge G, gray_addr<=addr_i, gray_req<=1, tag i enters a RD_LAT-deep shift pipe. With no grant, gray_req<=0 and gray_addr holds.
- Return: gray_data is valid in cycle G+RD_LAT and is sampled at the end of that cycle. Its tag selects rdata_tag<=gray_data and rvalid_tag<=1 for exactly cycle G+RD_LAT+1. Other rdata holds, other rvalid=0.
- Grant-to-rvalid latency: RD_LAT+1 (2 by default).
- Throughput: one read per cycle sustained. Back-to-back grants to either side, with the pipe carrying mixed tags, keep in-order per-tag routing.
- owner is updated on the same edge as the state.
- Reset mid-operation: in-flight reads are discarded. No rvalid is asserted in any cycle after reset is sampled, until a new grant completes.
- lock_i without req_i is ignored. Lock and burst count never apply to a requester that is not granted.
- Address and data pass through unmodified; no arithmetic on addresses.

Test Plan:
- Single requester: req0=1, addr0=0x0081, gray_ready=1, memory returns 0x5A. Expect gnt0 in cycle 0, gray_req=1 and gray_addr=0x0081 in cycle 1, rvalid0=1 and rdata0=0x5A in cycle 2, rvalid1 never 1.
- Round-robin: req0 and req1 held high with lock=0 for 6 cycles after reset. Grants alternate 0,1,0,1,0,1. rvalid pulses alternate the same way two cycles later, each with the correct data.
- Lock window: req0=lock0=1 with req1=1 throughout. Expect 9 consecutive gnt0 (MAX_BURST=9), then gnt1 on cycle 10. owner=01 during the burst and 00 after the forced release.
- Early release: in LOCKED_0, req0 drops at the 4th beat while req1=1. Expect gnt1 in that same cycle and owner=00 on the next edge.
- Stall: gray_ready=0 for 3 cycles with both req high. No gnt and gray_req=0 in that window; the lock count does not advance; arbitration resumes with the same pointer.
- Reset mid-flight: grant req1, then assert reset in cycle 1. No rvalid1 in cycle 2 or later; all outputs return to reset values.
